memory_access_pipe: RTL

MEMORY_ACCESS_PIPE -- requirements
Module: memory_access_pipe

---
 rtl/memory_access_pipe.sv | 132 +++++++++++++
 1 files changed

// File: rtl/memory_access_pipe.sv
// Memory-access pipeline stage: selects ALU/FPU result, issues one-cycle
// load/store requests, waits out the fixed memory latency, and hands off downstream.
module memory_access_pipe #(
  parameter int INST_MEM_WIDTH = 5,
  parameter int MEM_LATENCY    = 3,
  parameter int SIDE_WIDTH     = 40
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic                      aorf_result,
  input  logic [31:0]               alu_result,
  input  logic [31:0]               fpu_result,
  input  logic [31:0]               store_data,
  input  logic [INST_MEM_WIDTH-1:0] pc,
  input  logic [SIDE_WIDTH-1:0]     side_in,
  input  logic                      flush,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic                      mem_we,
  output logic                      mem_re,
  input  logic [31:0]               mem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_result,
  output logic [31:0]               out_read_data,
  output logic [INST_MEM_WIDTH-1:0] out_pc,
  output logic [SIDE_WIDTH-1:0]     out_side,
  output logic                      out_is_load
);

  // state  | meaning
  // S_IDLE | may accept; out_* hold the last completed instruction
  // S_WAIT | memory access outstanding, counting down to mem_rdata
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam int              CW       = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MEM_LATENCY - 1);

  state_t                    state, state_next;
  logic [CW-1:0]             cnt;
  logic [31:0]               result;
  logic                      is_mem;
  logic                      accept;
  logic [31:0]               hold_result;
  logic [INST_MEM_WIDTH-1:0] hold_pc;
  logic [SIDE_WIDTH-1:0]     hold_side;
  logic                      hold_load;

  assign result    = aorf_result ? fpu_result : alu_result;
  assign is_mem    = mem_read | mem_write;
  // Gated by reset so a request is never issued in a reset cycle
  assign in_ready  = (state == S_IDLE) && !flush && !reset && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mem_addr  = result;
  assign mem_wdata = store_data;
  assign mem_we    = accept && mem_write;
  assign mem_re    = accept && mem_read && !mem_write;

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept && is_mem) state_next = S_WAIT;
        S_WAIT: if (cnt == '0) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (reset || flush)                      cnt <= '0;
    else if (accept && is_mem)               cnt <= CNT_LOAD;
    else if (state == S_WAIT && cnt != '0)   cnt <= cnt - CW'(1);
  end

  // Memory ops park their sideband here so out_* stay valid-only data
  always_ff @(posedge CLK) begin
    if (reset) begin
      hold_result <= '0;
      hold_pc     <= '0;
      hold_side   <= '0;
      hold_load   <= 1'b0;
    end else if (accept && is_mem) begin
      hold_result <= result;
      hold_pc     <= pc;
      hold_side   <= side_in;
      hold_load   <= !mem_write;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_read_data <= '0;
      out_pc        <= '0;
      out_side      <= '0;
      out_is_load   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == S_IDLE && accept && !is_mem) begin
        out_valid     <= 1'b1;
        out_result    <= result;
        out_pc        <= pc;
        out_side      <= side_in;
        out_read_data <= '0;
        out_is_load   <= 1'b0;
      end else if (state == S_WAIT && cnt == '0) begin
        out_valid     <= 1'b1;
        out_result    <= hold_result;
        out_pc        <= hold_pc;
        out_side      <= hold_side;
        out_read_data <= mem_rdata;
        out_is_load   <= hold_load;
      end
    end
  end

endmodule
